// File: rtl/and_gate_arbiter_pkg.sv
// Shared state encodings and grant-counter constants for the round-robin AND arbiter.
package and_gate_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int                     GRANT_CNT_W   = 16;
    localparam logic [GRANT_CNT_W-1:0] GRANT_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/and_gate_vec.sv
// Purely combinational WIDTH-bit bitwise AND; the single datapath shared by all requesters.
module and_gate_vec #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a & b;

endmodule

// File: rtl/and_gate_arbiter.sv
// Round-robin arbiter sharing one AND datapath among NUM_REQ requesters.
// Optional saturating grant counter enabled by AND_GATE_ARBITER_STATS_EN.
module and_gate_arbiter
    import and_gate_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 1,
    parameter int IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         res,
    output logic [IDW-1:0]           res_id,
    output logic                     res_valid,
    output logic                     busy,
    output logic [GRANT_CNT_W-1:0]   grant_cnt
);

    state_t             state;
    state_t             next_state;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     sel_id;
    logic [IDW-1:0]     pick_id;
    logic [IDW-1:0]     pick_next;
    logic [WIDTH-1:0]   pick_a;
    logic [WIDTH-1:0]   pick_b;
    logic [WIDTH-1:0]   opa_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   and_out;
    logic [NUM_REQ-1:0] ack_dec;
    int                 best_dist;

    // Winner is the asserted request with the smallest forward distance from rr_ptr.
    always_comb begin
        pick_id   = '0;
        best_dist = NUM_REQ;
        pick_a    = '0;
        pick_b    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && ((i + NUM_REQ - int'(rr_ptr)) % NUM_REQ) < best_dist) begin
                best_dist = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
                pick_id   = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(pick_id)) begin
                pick_a = op_a[i*WIDTH +: WIDTH];
                pick_b = op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign pick_next = (int'(pick_id) == NUM_REQ - 1) ? '0 : pick_id + IDW'(1);

    always_comb begin
        ack_dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_dec[i] = (i == int'(sel_id));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The unused encoding falls into default and recovers to IDLE.
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE:  next_state = (|req) ? ST_GRANT : ST_IDLE;
            ST_GRANT: next_state = ST_DONE;
            default:  next_state = ST_IDLE;
        endcase
    end

    and_gate_vec #(
        .WIDTH (WIDTH)
    ) u_and (
        .a (opa_q),
        .b (opb_q),
        .y (and_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            sel_id    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res       <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
            ack       <= '0;
        end else begin
            res_valid <= 1'b0;
            ack       <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        sel_id <= pick_id;
                        opa_q  <= pick_a;
                        opb_q  <= pick_b;
                        rr_ptr <= pick_next;
                    end
                end
                ST_GRANT: begin
                    res       <= and_out;
                    res_id    <= sel_id;
                    res_valid <= 1'b1;
                    ack       <= ack_dec;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_GRANT) || (state == ST_DONE);

`ifdef AND_GATE_ARBITER_STATS_EN
    logic [GRANT_CNT_W-1:0] grant_cnt_q;

    // Every GRANT cycle is followed by DONE, so GRANT marks a completed grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else if (state == ST_GRANT && grant_cnt_q != GRANT_CNT_MAX) begin
            grant_cnt_q <= grant_cnt_q + 1'b1;
        end
    end

    assign grant_cnt = grant_cnt_q;
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_and_gate_arbiter.sv
// Directed bench for and_gate_arbiter (NUM_REQ=4, WIDTH=4, plus a WIDTH=1 instance).
module tb_and_gate_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  ack;
    logic [3:0]  res;
    logic [1:0]  res_id;
    logic        res_valid;
    logic        busy;
    logic [15:0] grant_cnt;

    logic [3:0]  req1;
    logic [3:0]  op_a1;
    logic [3:0]  op_b1;
    logic [3:0]  ack1;
    logic [0:0]  res1;
    logic [1:0]  res_id1;
    logic        res_valid1;
    logic        busy1;
    logic [15:0] grant_cnt1;

    int compared   = 0;
    int mismatched = 0;

    logic [3:0] rr_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       w1_a   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic       w1_b   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       w1_exp [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    and_gate_arbiter #(.NUM_REQ(4), .WIDTH(4), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .ack       (ack),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    and_gate_arbiter #(.NUM_REQ(4), .WIDTH(1), .IDW(2)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .req       (req1),
        .op_a      (op_a1),
        .op_b      (op_b1),
        .ack       (ack1),
        .res       (res1),
        .res_id    (res_id1),
        .res_valid (res_valid1),
        .busy      (busy1),
        .grant_cnt (grant_cnt1)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef AND_GATE_ARBITER_STATS_EN
        return n;
`else
        return 16'd0;
`endif
    endfunction

    initial begin
        rst   = 1'b1;
        req   = 4'b1111;
        op_a  = {4'd3, 4'd2, 4'd1, 4'd0};
        op_b  = {4'd3, 4'd2, 4'd1, 4'd0};
        req1  = 4'b0000;
        op_a1 = 4'b0000;
        op_b1 = 4'b0000;

        // Reset held two cycles with all requests high
        step();
        step();
        check("rst_ack", ack, 0);
        check("rst_res", res, 0);
        check("rst_res_id", res_id, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_cnt", grant_cnt, 0);
        rst = 1'b0;
        check("rel_ack_now", ack, 0);

        // Round robin with all requests held: 0,1,2,3,0, three cycles apart
        for (int i = 0; i < 5; i++) begin
            step();
            check("rr_gap_ack", ack, 0);
            check("rr_gap_busy", busy, 1);
            step();
            check("rr_ack", ack, rr_ack[i]);
            check("rr_res", res, rr_id[i]);
            check("rr_res_id", res_id, rr_id[i]);
            check("rr_res_valid", res_valid, 1);
            if (i == 4) req = 4'b0000;
            step();
            check("rr_idle_ack", ack, 0);
            check("rr_idle_busy", busy, 0);
        end
        check("cnt_after_5", grant_cnt, exp_cnt(16'd5));

        // Single request on id 2; operand change after sampling must not matter
        op_a = 16'h0C00;
        op_b = 16'h0A00;
        req  = 4'b0100;
        step();
        check("single_grant_ack", ack, 0);
        op_a = 16'h0000;
        step();
        check("single_ack", ack, 4'b0100);
        check("single_res", res, 4'b1000);
        check("single_res_id", res_id, 2);
        check("single_valid", res_valid, 1);
        req = 4'b0000;
        step();
        check("single_ack_drop", ack, 0);
        check("single_valid_drop", res_valid, 0);
        check("single_res_hold", res, 4'b1000);
        check("single_id_hold", res_id, 2);

        // Wrap: serve 3, then 1 with no stall, then 3 before 0 from rr_ptr=2
        op_a = 16'hF000;
        op_b = 16'h5000;
        req  = 4'b1000;
        step();
        step();
        check("wrap3_ack", ack, 4'b1000);
        check("wrap3_res", res, 4'h5);
        check("wrap3_id", res_id, 3);
        req  = 4'b0010;
        op_a = 16'h00E0;
        op_b = 16'h0070;
        step();
        step();
        step();
        check("skip1_ack", ack, 4'b0010);
        check("skip1_res", res, 4'h6);
        check("skip1_id", res_id, 1);
        req  = 4'b1001;
        op_a = 16'h900C;
        op_b = 16'h300A;
        step();
        step();
        step();
        check("pair_first_ack", ack, 4'b1000);
        check("pair_first_res", res, 4'h1);
        req = 4'b0001;
        step();
        step();
        step();
        check("pair_second_ack", ack, 4'b0001);
        check("pair_second_res", res, 4'h8);
        check("pair_second_id", res_id, 0);
        req = 4'b0000;
        step();
        check("cnt_after_10", grant_cnt, exp_cnt(16'd10));

        // Abort during GRANT; rr_ptr must restart at 0
        op_a = 16'h00F0;
        op_b = 16'h00F0;
        req  = 4'b0010;
        step();
        check("abort_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_imm_ack", ack, 0);
        check("abort_imm_busy", busy, 0);
        check("abort_imm_valid", res_valid, 0);
        check("abort_imm_res", res, 0);
        step();
        check("abort_ack", ack, 0);
        check("abort_valid", res_valid, 0);
        check("abort_cnt", grant_cnt, 0);
        rst  = 1'b0;
        req  = 4'b1010;
        op_a = 16'hC070;
        op_b = 16'hC030;
        step();
        check("post_abort_gap", ack, 0);
        step();
        check("post_abort_ack", ack, 4'b0010);
        check("post_abort_id", res_id, 1);
        check("post_abort_res", res, 4'h3);
        req = 4'b1000;
        step();
        check("post_abort_cnt", grant_cnt, exp_cnt(16'd1));
        step();
        step();
        check("post_abort_ack3", ack, 4'b1000);
        check("post_abort_res3", res, 4'hC);
        req = 4'b0000;
        step();

`ifdef AND_GATE_ARBITER_STATS_EN
        // Saturation of the grant counter
        force dut.grant_cnt_q = 16'hFFFE;
        #1;
        release dut.grant_cnt_q;
        check("sat_preset", grant_cnt, 16'hFFFE);
        op_a = 16'h000F;
        op_b = 16'h000F;
        for (int g = 0; g < 3; g++) begin
            req = 4'b0001;
            step();
            step();
            check("sat_ack", ack, 4'b0001);
            req = 4'b0000;
            step();
            check("sat_cnt", grant_cnt, 16'hFFFF);
        end
`else
        check("nostat_cnt", grant_cnt, 16'd0);
`endif

        // WIDTH=1 instance: every a/b combination on requester 0
        for (int j = 0; j < 4; j++) begin
            req1  = 4'b0001;
            op_a1 = {3'b000, w1_a[j]};
            op_b1 = {3'b000, w1_b[j]};
            step();
            step();
            check("w1_ack", ack1, 4'b0001);
            check("w1_res", res1, w1_exp[j]);
            check("w1_res_id", res_id1, 0);
            check("w1_valid", res_valid1, 1);
            req1 = 4'b0000;
            step();
        end
        check("w1_busy_end", busy1, 0);
        check("w1_cnt_end", grant_cnt1, exp_cnt(16'd4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
